// File: rtl/p_controller_if.sv
// rtl/p_controller_if.sv - sample/duty handshake bundle between the control sequencer and the p_controller
//
// Signals:
//   setpoint, measured  unsigned 8-bit target and feedback
//   kp                  unsigned fixed-point gain, KP_WIDTH bits
//   sample_valid        request to start one computation
//   duty_cycle          registered duty value to the PWM stage
//   duty_valid          one-cycle strobe, duty_cycle updated this cycle
//   busy                computation in progress
//   overrun             one-cycle strobe, a request was dropped while busy
// Modports: master drives the sample side, slave is the controller.
interface p_controller_if #(
    parameter int KP_WIDTH = 8
);
    logic [7:0]          setpoint;
    logic [7:0]          measured;
    logic [KP_WIDTH-1:0] kp;
    logic                sample_valid;
    logic [7:0]          duty_cycle;
    logic                duty_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output setpoint, measured, kp, sample_valid,
        input  duty_cycle, duty_valid, busy, overrun
    );

    modport slave (
        input  setpoint, measured, kp, sample_valid,
        output duty_cycle, duty_valid, busy, overrun
    );
endinterface

// File: rtl/p_controller.sv
// rtl/p_controller.sv - proportional control stage: (setpoint - measured) * kp + bias, saturated to an 8-bit duty
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      p_controller_if.slave (sample inputs, duty/valid/busy/overrun outputs)
// The gain multiply is a serial shift-add, one kp bit per cycle LSB first, so a
// result is ready KP_WIDTH+1 cycles after the sample is captured.
module p_controller #(
    parameter int KP_WIDTH  = 8,
    parameter int FRAC_BITS = 4,
    parameter int BIAS      = 128,
    parameter int DUTY_MIN  = 0,
    parameter int DUTY_MAX  = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    p_controller_if.slave bus
);
    localparam int ACC_W = 18;
    localparam int CNT_W = $clog2(KP_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        SAT
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  addend;   // error << i for the current cycle
    logic [KP_WIDTH-1:0]      kp_sh;    // captured gain, consumed from bit 0 upward
    logic [CNT_W-1:0]         bit_cnt;

    logic signed [8:0]        err_in;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [ACC_W-1:0]  sum;
    logic [7:0]               clamped;

    // Both operands are zero-extended to 9 bits, so the difference spans -255..255.
    assign err_in = $signed({1'b0, bus.setpoint}) - $signed({1'b0, bus.measured});

    always_comb begin
        scaled = acc >>> FRAC_BITS;
        sum    = signed'(ACC_W'(BIAS)) + scaled;
        if (sum < signed'(ACC_W'(DUTY_MIN))) begin
            clamped = 8'(DUTY_MIN);
        end else if (sum > signed'(ACC_W'(DUTY_MAX))) begin
            clamped = 8'(DUTY_MAX);
        end else begin
            clamped = sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            acc            <= '0;
            addend         <= '0;
            kp_sh          <= '0;
            bit_cnt        <= '0;
            bus.duty_cycle <= 8'(DUTY_MIN);
            bus.duty_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.duty_valid <= 1'b0;
            // Any request seen outside IDLE (including SAT) is dropped and flagged.
            bus.overrun    <= bus.sample_valid && (state != IDLE);

            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        addend   <= ACC_W'(err_in);
                        kp_sh    <= bus.kp;
                        acc      <= '0;
                        bit_cnt  <= '0;
                        bus.busy <= 1'b1;
                        state    <= MULT;
                    end
                end
                MULT: begin
                    if (kp_sh[0]) begin
                        acc <= acc + addend;
                    end
                    addend  <= addend <<< 1;
                    kp_sh   <= kp_sh >> 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(KP_WIDTH - 1)) begin
                        state <= SAT;
                    end
                end
                SAT: begin
                    bus.duty_cycle <= clamped;
                    bus.duty_valid <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_p_controller.sv
// tb/tb_p_controller.sv - randomized self-checking bench for p_controller against an arithmetic reference
module tb_p_controller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    p_controller_if #(.KP_WIDTH(8)) bus ();

    p_controller #(
        .KP_WIDTH (8),
        .FRAC_BITS(4),
        .BIAS     (128),
        .DUTY_MIN (0),
        .DUTY_MAX (255)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int last_duty = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Gain is Q4.4: real duty = 128 + floor((sp - ms) * kp / 16), clamped to 0..255.
    function automatic int ref_duty(input int sp, input int ms, input int k);
        int prod;
        int q;
        prod = (sp - ms) * k;
        q = prod / 16;
        if ((prod % 16 != 0) && (prod < 0)) q = q - 1;
        q = 128 + q;
        if (q < 0) q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.sample_valid = 1'b0;
            step();
            check({tag, "_no_valid"}, int'(bus.duty_valid), 0);
            check({tag, "_hold"}, int'(bus.duty_cycle), last_duty);
        end
    endtask

    // Drives one sample; returns in the duty_valid cycle so a following call
    // exercises back-to-back acceptance. ovr_at >= 0 fires an extra request at
    // that cycle offset after capture; scramble changes inputs mid-multiply.
    task automatic do_sample(input int sp, input int ms, input int k,
                             input int ovr_at, input bit scramble, input string tag);
        int lat;
        int busy_cnt;
        int ovr_cnt;
        int exp;
        bit got;
        exp = ref_duty(sp, ms, k);
        bus.setpoint     = 8'(sp);
        bus.measured     = 8'(ms);
        bus.kp           = 8'(k);
        bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
        lat = 0;
        busy_cnt = 0;
        ovr_cnt = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (ovr_at >= 0 && lat == ovr_at + 1) bus.sample_valid = 1'b0;
            if (ovr_at >= 0 && lat == ovr_at) begin
                bus.sample_valid = 1'b1;
                bus.setpoint     = 8'($urandom);
                bus.measured     = 8'($urandom);
                bus.kp           = 8'($urandom);
            end
            if (scramble && lat == 2) begin
                bus.setpoint = 8'($urandom);
                bus.measured = 8'($urandom);
                bus.kp       = 8'($urandom);
            end
            if (bus.overrun) ovr_cnt++;
            if (bus.duty_valid) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                if (lat == 4) check({tag, "_hold_mid"}, int'(bus.duty_cycle), last_duty);
                step();
                lat++;
            end
        end
        bus.sample_valid = 1'b0;
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_busy_at_done"}, int'(bus.busy), 0);
        check({tag, "_duty"}, int'(bus.duty_cycle), exp);
        check({tag, "_overrun"}, ovr_cnt, (ovr_at >= 0) ? 1 : 0);
        last_duty = exp;
    endtask

    initial begin
        bus.setpoint     = '0;
        bus.measured     = '0;
        bus.kp           = '0;
        bus.sample_valid = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        check("rst_duty", int'(bus.duty_cycle), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.duty_valid), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        reset_n = 1'b1;
        last_duty = 0;
        idle_gap(2, "post_rst");

        do_sample(200, 100, 16, -1, 1'b0, "nom_pos");
        idle_gap(1, "nom_pos_pulse");
        do_sample(100, 200, 16, -1, 1'b0, "nom_neg");
        idle_gap(1, "nom_neg_pulse");
        do_sample(99, 100, 1, -1, 1'b0, "floor");
        do_sample(37, 201, 0, -1, 1'b0, "kp_zero");
        do_sample(150, 50, 32, -1, 1'b0, "sat_hi");
        do_sample(50, 150, 32, -1, 1'b0, "sat_lo");
        do_sample(255, 0, 255, -1, 1'b0, "sat_max");
        do_sample(0, 255, 255, -1, 1'b0, "sat_min");
        idle_gap(2, "gap");

        do_sample(150, 50, 20, 3, 1'b0, "overrun");
        do_sample(120, 90, 24, -1, 1'b0, "b2b");
        idle_gap(1, "b2b_pulse");
        do_sample(180, 60, 12, -1, 1'b1, "stable");
        idle_gap(1, "stable_pulse");

        bus.setpoint     = 8'd250;
        bus.measured     = 8'd10;
        bus.kp           = 8'd40;
        bus.sample_valid = 1'b1;
        step();
        bus.sample_valid = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        step();
        check("midrst_duty", int'(bus.duty_cycle), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_valid", int'(bus.duty_valid), 0);
        reset_n = 1'b1;
        last_duty = 0;
        idle_gap(12, "midrst_quiet");
        do_sample(90, 70, 48, -1, 1'b0, "after_rst");

        for (int n = 0; n < 150; n++) begin
            int sp;
            int ms;
            int k;
            int ovr;
            sp  = int'($urandom_range(0, 255));
            ms  = int'($urandom_range(0, 255));
            k   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255));
            ovr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
            do_sample(sp, ms, k, ovr, 1'($urandom_range(0, 1)), "rand");
            idle_gap(int'($urandom_range(0, 2)), "rand_gap");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/p_controller.md
# p_controller

Proportional control stage sitting directly upstream of the PWM generator. It samples a setpoint and a measured value and computes `error = setpoint - measured`. It scales the error by a programmable gain using a serial shift-add multiplier, adds a bias, saturates, and registers the result as the 8-bit `duty_cycle` consumed by the PWM stage. One computation runs per accepted sample; `duty_valid` strobes when the new duty value is in effect.

## Interface
- KP_WIDTH, 8: width of `kp`; also the number of multiply cycles.
- FRAC_BITS, 4: fractional bits of `kp` (unsigned fixed-point; default Q4.4, so kp=16 is gain 1.0).
- BIAS, 128: duty value output at zero error.
- DUTY_MIN, 0: lower clamp and reset value of `duty_cycle`.
- DUTY_MAX, 255: upper clamp.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset: synchronous, active-low.
- setpoint  in  8  unsigned target.
- measured  in  8  unsigned feedback value.
- kp  in  KP_WIDTH  unsigned gain.
- sample_valid  in  1  request to start a computation.
- duty_cycle  out  8  registered duty to the PWM stage.
- duty_valid  out  1  one-cycle pulse; `duty_cycle` was updated this cycle.
- busy  out  1  computation in progress.
- overrun  out  1  one-cycle pulse; `sample_valid` arrived while busy and was dropped.

## Operation
- FSM states: IDLE, MULT, SAT. `busy` = (state != IDLE).
- IDLE: if `sample_valid`=1, capture `setpoint`, `measured` and `kp`.
  - error = setpoint - measured, 9-bit signed, range -255..255.
  - Clear the accumulator and the bit counter, then go to MULT.
- MULT: runs KP_WIDTH cycles, LSB first. In cycle i, if kp_reg[i]=1, add (sign-extended error << i) to an 18-bit signed accumulator. After the last bit, go to SAT.
- SAT, one cycle:
  - scaled = acc >>> FRAC_BITS (arithmetic shift, floor toward -inf).
  - sum = BIAS + scaled, computed in 18-bit signed.
  - Clamp sum to [DUTY_MIN, DUTY_MAX].
  - Register the result to `duty_cycle`, pulse `duty_valid`, return to IDLE.
- `duty_cycle` holds its value between updates; the PWM stage may sample it at any time.
- `sample_valid` while busy: dropped, not queued. `overrun` pulses the following cycle. No state is disturbed.
- Inputs are sampled only at the capture edge; changes during MULT/SAT have no effect.
- reset_n=0 at any time:
  - state → IDLE, `duty_cycle` → DUTY_MIN.
  - `duty_valid`, `busy` and `overrun` → 0.
  - Any in-flight computation is aborted with no `duty_valid`.

## Timing
- Capture edge E: `sample_valid`=1 and state IDLE.
- `busy`=1 from E+1 through E+KP_WIDTH+1.
- `duty_valid`=1 and the new `duty_cycle` are visible in the cycle after edge E+KP_WIDTH+1. With defaults, that is 9 cycles after capture.
- In that same cycle, `busy`=0. A `sample_valid` asserted in that cycle is accepted, which gives back-to-back throughput of one result per KP_WIDTH+1 cycles.
- `duty_valid` is high for exactly one cycle per completed computation.
- `overrun` is registered: it is high in the cycle after the dropped request.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Nominal positive: setpoint=200, measured=100, kp=16 → `duty_cycle`=228. `duty_valid` arrives exactly 9 cycles after capture, and `busy` is high for 9 cycles.
- Nominal negative and rounding:
  - setpoint=100, measured=200, kp=16 → 28.
  - setpoint=99, measured=100, kp=1 → 127 (floor of -1/16).
  - kp=0 → 128.
- Saturation:
  - error=+100, kp=32 → 255 (unclamped 328).
  - error=-100, kp=32 → 0 (unclamped -72).
  - setpoint=255, measured=0, kp=255 → 255.
  - setpoint=0, measured=255, kp=255 → 0.
- Overrun: pulse `sample_valid` at cycle 3 of a computation → `overrun` pulses once, and the result matches the original sample. A request in the `duty_valid` cycle is accepted, with its result 9 cycles later.
- Input stability: change `setpoint`/`measured`/`kp` during MULT → the result reflects the captured values only.
- Reset: assert reset_n=0 mid-MULT → `duty_cycle`=0 and `busy`=0 next cycle, with no `duty_valid`. After release, a fresh sample computes correctly.
